// File: rtl/tmp_reg_arbiter.sv
// TMP10X register file and arbiter: shares four sensor registers between the
// I2C slave (async byte strobes) and the conversion side, and drives Alert.

module tmp_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic evt
);
    logic [2:0] sync;

    // Two metastability flops, a delay flop, then a registered rising-edge pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= 3'b000;
            evt  <= 1'b0;
        end else begin
            sync <= {sync[1:0], din};
            evt  <= sync[1] & ~sync[2];
        end
    end
endmodule

module tmp_reg_arbiter #(
    parameter int                       ADDRESSLENGTH = 7,
    parameter logic [ADDRESSLENGTH-1:0] DEVADDR       = 7'h48
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic [ADDRESSLENGTH-1:0] DirectionBuffer,
    output logic                     HaveAddress,
    input  logic                     I2cStart,
    input  logic                     I2cStrobe,
    input  logic                     RorW,
    input  logic [7:0]               InputBuffer,
    output logic [7:0]               OutputBuffer,
    input  logic                     SensReq,
    input  logic [7:0]               SensData,
    output logic                     SensAck,
    output logic                     Alert
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_I2C,
        S_SENS
    } state_t;

    state_t          state, state_nxt;
    logic [3:0][7:0] regs;
    logic [1:0]      ptr;
    logic            first_byte;
    logic            pending;
    logic            raw_alert, raw_nxt;
    logic            start_evt, strobe_evt;

    assign HaveAddress = (DirectionBuffer == DEVADDR);

    tmp_edge_sync u_start_sync (
        .clk (Clk),
        .rst (Reset),
        .din (I2cStart),
        .evt (start_evt)
    );

    tmp_edge_sync u_strobe_sync (
        .clk (Clk),
        .rst (Reset),
        .din (I2cStrobe),
        .evt (strobe_evt)
    );

    // I2C always wins over the conversion side
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (strobe_evt || pending) state_nxt = S_I2C;
                else if (SensReq)          state_nxt = S_SENS;
            end
            S_I2C:   state_nxt = S_IDLE;
            S_SENS:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Thermostat hysteresis, signed compare against TOS (reg3) and THYST (reg2)
    always_comb begin
        raw_nxt = raw_alert;
        if (state == S_SENS) begin
            if ($signed(SensData) >= $signed(regs[3]))     raw_nxt = 1'b1;
            else if ($signed(SensData) < $signed(regs[2])) raw_nxt = 1'b0;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            regs         <= {8'h50, 8'h4B, 8'h00, 8'h00};
            ptr          <= 2'd0;
            first_byte   <= 1'b1;
            pending      <= 1'b0;
            raw_alert    <= 1'b0;
            Alert        <= 1'b0;
            SensAck      <= 1'b0;
            OutputBuffer <= 8'h00;
        end else begin
            OutputBuffer <= regs[ptr];
            SensAck      <= (state == S_SENS);
            raw_alert    <= raw_nxt;
            Alert        <= raw_nxt ^ regs[1][2];

            // One strobe may arrive while busy; it is served on the next IDLE
            if (state != S_IDLE && strobe_evt) pending <= 1'b1;
            else if (state == S_IDLE)          pending <= 1'b0;

            case (state)
                S_I2C: begin
                    if (RorW) begin
                        if (first_byte) begin
                            ptr        <= InputBuffer[1:0];
                            first_byte <= 1'b0;
                        end else begin
                            // TEMP is read-only from the bus
                            if (ptr != 2'd0) regs[ptr] <= InputBuffer;
                            ptr <= ptr + 2'd1;
                        end
                    end else begin
                        ptr <= ptr + 2'd1;
                    end
                end
                S_SENS: regs[0] <= SensData;
                default: ;
            endcase

            // Start takes effect after any concurrent I2C access so it wins
            if (start_evt) first_byte <= 1'b1;
        end
    end
endmodule

// File: doc/tmp_reg_arbiter.md
# tmp_reg_arbiter

Register-file controller and arbiter behind the I2C slave control unit of the TMP10X sensor. Owns the four 8-bit sensor registers and shares them between two requesters: the I2C bus side (byte strobes crossing from the Scl domain) and the local temperature-conversion side (synchronous write requests). Also decodes the device address for the I2C slave and produces the thermostat Alert output.

## Interface
- ADDRESSLENGTH, 7, width of the I2C device address
- DEVADDR, 7'h48, device address answered on the bus
- Clk  in  1  system clock; all state on rising edge
- Reset  in  1  asynchronous, active-high; clears all state immediately
- DirectionBuffer  in  ADDRESSLENGTH  address captured by the I2C slave unit
- HaveAddress  out  1  combinational, DirectionBuffer == DEVADDR
- I2cStart  in  1  async level from the slave unit; rising edge marks a new transaction
- I2cStrobe  in  1  async level; rising edge marks one data byte completed (write) or consumed (read)
- RorW  in  1  transfer direction from the slave unit; 1 = master writes, 0 = master reads; stable while I2cStrobe is high
- InputBuffer  in  8  byte written by master; stable while I2cStrobe is high
- OutputBuffer  out  8  registered, reg[Ptr]; byte the slave shifts out on reads
- SensReq  in  1  synchronous level; conversion side requests a write of SensData to reg0
- SensData  in  8  new temperature, two's complement; stable while SensReq is high
- SensAck  out  1  one-cycle pulse; write to reg0 done
- Alert  out  1  registered thermostat output

## Operation
- Registers: reg0 TEMP (read-only from I2C, reset 8'h00), reg1 CONFIG (reset 8'h00), reg2 THYST (reset 8'h4B), reg3 TOS (reset 8'h50). Internal Ptr 2 bits (reset 0), FirstByte flag (reset 1).
- I2cStart and I2cStrobe each pass through a 2-flop synchronizer plus a delay flop; an event is sync2 & !sync3. Sync flops reset to 0.
- Start event: FirstByte <= 1. Ptr is not changed.
- FSM states IDLE, I2C, SENS; reset IDLE.
- IDLE: a strobe event, or a latched pending I2C strobe -> I2C. Otherwise SensReq high -> SENS. I2C has fixed priority over the sensor.
- I2C (one cycle), then -> IDLE:
  - RorW=1 with FirstByte=1: Ptr <= InputBuffer[1:0], FirstByte <= 0.
  - RorW=1 with FirstByte=0: if Ptr != 0, reg[Ptr] <= InputBuffer (a write to reg0 is discarded). Ptr <= Ptr+1.
  - RorW=0: Ptr <= Ptr+1.
  - Ptr arithmetic is modulo 4; 3 wraps to 0.
- SENS (one cycle), then -> IDLE: reg0 <= SensData; SensAck = 1; evaluate Alert.
- A strobe event occurring while in I2C or SENS sets a pending flag, which is consumed on the next IDLE. Only one event is queued; strobes are spaced much further apart than that in practice.
- Alert evaluation is signed 8-bit:
  - raw <= 1 if SensData >= TOS.
  - raw <= 0 if SensData < THYST.
  - Otherwise raw holds.
  - Alert = raw ^ CONFIG[2]; CONFIG[2] is polarity.
  - THYST/TOS writes do not re-evaluate raw.
- OutputBuffer <= reg[Ptr] every cycle in all states.

## Timing
- Requirement: Clk frequency >= 16x Scl frequency.
- I2cStrobe rising sampled at edge k: event visible after edge k+2; FSM in I2C after k+3; register/Ptr updated at k+4; OutputBuffer shows the new reg[Ptr] at k+5.
- SensReq high at edge j in IDLE with no I2C work: SENS after j; reg0, Alert and SensAck high after j+1; SensAck low after j+2. SensReq still high at j+2 is treated as a new request.
- Simultaneous start and strobe events: the start is applied first, so that strobe is treated as the first byte.
- Simultaneous strobe event and SensReq in IDLE: I2C is served first; SENS follows on the next IDLE cycle.
- Reset asserted mid-access: all registers, Ptr, FSM, sync flops, SensAck=0 and Alert=0 return to reset values at once; no partial write is retained.
- Reset values of outputs: OutputBuffer 8'h00 (reg0 at Ptr 0), SensAck 0, Alert 0. HaveAddress follows its input.

## Test plan
- After reset: read 4 bytes via strobes with RorW=0 -> OutputBuffer sequence 00, 00, 4B, 50; Ptr wraps to 0.
- Start, write bytes 01, 06 -> reg1=06, Ptr=2; then write byte 55 -> reg2=55, Ptr=3.
- Start, write 00 then A5 -> reg0 unchanged, Ptr=1.
- SensReq with SensData=51 (TOS=50) -> SensAck one cycle, Alert=1; SensData=4C -> Alert stays 1; SensData=4A -> Alert=0; set CONFIG[2]=1 -> Alert=1.
- Strobe event and SensReq in the same cycle -> I2C access completes first, SensAck exactly one cycle later; SensData=F0 (-16) gives Alert=0.
- Reset pulse during the I2C state -> no register write, all outputs at reset values; DirectionBuffer=48 gives HaveAddress=1, 49 gives 0.
